// File: rtl/bus_pkg.sv
// Shared data-bus definitions: SIZE encodings and the responder FSM states.
// Imported by both the processor side and the memory responder.
package bus_pkg;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10,
    SZ_RSVD = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    ACK  = 2'b10
  } state_t;

  // SIZE=11 falls through to a full-word access.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: byte_en = 4'b0001 << lo;
      SZ_HALF: byte_en = lo[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Data-bus request/acknowledge group. DDT stays a separate inout port because
// it is a resolved tristate net shared by both ends.
interface data_mem_responder_if;
  logic        MREQ;
  logic        WRITE;
  logic [1:0]  SIZE;
  logic [31:0] DAD;
  logic        ACKD_n;

  modport master (output MREQ, WRITE, SIZE, DAD, input ACKD_n);
  modport slave  (input MREQ, WRITE, SIZE, DAD, output ACKD_n);
endinterface

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: byte enables and replicated write lanes for a
// store, right-aligned zero-extended extraction for a load.
module mem_lane_align
  import bus_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wlanes,
  output logic [31:0] rdata
);

  logic [31:0] rshift;

  always_comb begin
    be     = byte_en(size, addr_lo);
    wlanes = wdata;
    rdata  = rword;
    rshift = rword >> {addr_lo, 3'b000};
    case (size)
      SZ_BYTE: begin
        // Replicating the source byte lets the enables alone pick the lane.
        wlanes = {4{wdata[7:0]}};
        rdata  = {24'h0, rshift[7:0]};
      end
      SZ_HALF: begin
        wlanes = {2{wdata[15:0]}};
        rdata  = {16'h0, (addr_lo[1] ? rword[31:16] : rword[15:0])};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side end of the MREQ/ACKD_n data bus: programmable wait states,
// byte/half/word access on a word array, tristate read data on DDT.
module data_mem_responder
  import bus_pkg::*;
#(
  parameter int    DEPTH_WORDS = 1024,
  parameter int    WAIT_CYCLES = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus,
  inout  wire  [31:0]          DDT
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t             state_q, state_next;
  logic [CNT_W-1:0]   cnt_q, cnt_next;
  logic [IDX_W+1:0]   addr_q;
  logic               write_q;
  logic [1:0]         size_q;
  logic [31:0]        wdata_q;
  logic               accept;

  logic [31:0]        mem [DEPTH_WORDS];
  logic [31:0]        mem_word_q;
  logic [IDX_W-1:0]   idx, rd_idx;
  logic               rd_en, mem_we, ddt_oe;
  logic [3:0]         be;
  logic [31:0]        wlanes, rdata;

  always_comb begin
    state_next = state_q;
    cnt_next   = cnt_q;
    accept     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.MREQ) begin
          accept     = 1'b1;
          cnt_next   = CNT_LOAD;
          state_next = (WAIT_CYCLES > 0) ? WAIT : ACK;
        end
      end
      WAIT: begin
        // Dropping MREQ while waiting abandons the request without an ACK.
        if (!bus.MREQ)          state_next = IDLE;
        else if (cnt_q == '0)   state_next = ACK;
        else                    cnt_next   = cnt_q - CNT_ONE;
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_next;
      cnt_q   <= cnt_next;
      if (accept) begin
        addr_q  <= bus.DAD[IDX_W+1:0];
        write_q <= bus.WRITE;
        size_q  <= bus.SIZE;
        wdata_q <= DDT;
      end
    end
  end

  mem_lane_align u_align (
    .size    (size_q),
    .addr_lo (addr_q[1:0]),
    .wdata   (wdata_q),
    .rword   (mem_word_q),
    .be      (be),
    .wlanes  (wlanes),
    .rdata   (rdata)
  );

  // With zero wait states the read launches on the accepting edge, before
  // addr_q holds the new address, so take the index straight from DAD then.
  assign idx    = addr_q[IDX_W+1:2];
  assign rd_idx = (state_q == IDLE) ? bus.DAD[IDX_W+1:2] : idx;
  assign rd_en  = (state_next == ACK);
  assign mem_we = (state_q == ACK) && write_q && !rst;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][b*8 +: 8] <= wlanes[b*8 +: 8];
      end
    end
    if (rd_en) mem_word_q <= mem[rd_idx];
  end

  assign ddt_oe     = (state_q == ACK) && !write_q;
  assign DDT        = ddt_oe ? rdata : 32'hz;
  assign bus.ACKD_n = (state_q != ACK);

endmodule
